// File: rtl/oam_dma_controller_pkg.sv
// Shared constants, state encoding and bus helpers for the OAM DMA engine.
// Address map values mirror the DMA register, OAM window and HRAM window.
package oam_dma_controller_pkg;

  localparam logic [15:0] REG_DMA  = 16'hFF46;
  localparam logic [15:0] OAM_BASE = 16'hFE00;
  localparam logic [15:0] HRAM_LO  = 16'hFF80;
  localparam logic [15:0] HRAM_HI  = 16'hFFFE;
  localparam int          DMA_LEN  = 160;
  localparam logic [7:0]  LAST_IDX = 8'(DMA_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    WAIT  = 2'd3
  } dma_state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  dat;
    logic        rd_n;
    logic        wr_n;
  } mem_bus_t;

  // Pages E0-FF alias echo RAM; fold them back onto C0-DF.
  function automatic logic [7:0] remap_src(input logic [7:0] page);
    return (page >= 8'hE0) ? (page - 8'h20) : page;
  endfunction

  function automatic logic in_hram(input logic [15:0] addr);
    return (addr >= HRAM_LO) && (addr <= HRAM_HI);
  endfunction

endpackage

// File: rtl/oam_dma_controller.sv
// OAM DMA engine at FF46: copies 160 bytes to FE00, one byte per BYTE_CYCLES clocks.
// Owns the CPU bus while active; HRAM accesses stall the copy, all others are blocked.
module oam_dma_controller
  import oam_dma_controller_pkg::*;
#(
  parameter int BYTE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] A_cpu,
  input  logic [7:0]  Di_cpu,
  output logic [7:0]  Do_cpu,
  input  logic        rd_cpu_n,
  input  logic        wr_cpu_n,
  output logic [15:0] A_mem,
  output logic [7:0]  Do_mem,
  input  logic [7:0]  Di_mem,
  output logic        rd_mem_n,
  output logic        wr_mem_n,
  output logic        dma_active
);

  localparam int WAIT_W = (BYTE_CYCLES > 3) ? $clog2(BYTE_CYCLES - 2) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'((BYTE_CYCLES > 2) ? (BYTE_CYCLES - 3) : 0);

  dma_state_t        state;
  logic [7:0]        src_raw;
  logic [7:0]        src_eff;
  logic [7:0]        idx;
  logic [WAIT_W-1:0] wait_cnt;
  logic [7:0]        latch;
  logic              wr_prev;

  logic     is_reg;
  logic     cpu_hram;
  logic     stall;
  logic     trigger;
  logic     byte_end;
  mem_bus_t bus;

  assign is_reg   = (A_cpu == REG_DMA);
  assign cpu_hram = (!rd_cpu_n || !wr_cpu_n) && in_hram(A_cpu);
  assign stall    = (state != IDLE) && cpu_hram;
  assign trigger  = wr_prev && !wr_cpu_n && is_reg;
  assign byte_end = ((state == WRITE) && (BYTE_CYCLES == 2)) ||
                    ((state == WAIT) && (wait_cnt == '0));

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      src_raw    <= 8'h00;
      src_eff    <= 8'h00;
      idx        <= 8'h00;
      wait_cnt   <= '0;
      latch      <= 8'h00;
      wr_prev    <= 1'b1;
      dma_active <= 1'b0;
    end else begin
      wr_prev <= wr_cpu_n;
      if (trigger) begin
        // A new FF46 write always wins, even mid-copy.
        src_raw    <= Di_cpu;
        src_eff    <= remap_src(Di_cpu);
        idx        <= 8'h00;
        wait_cnt   <= '0;
        state      <= READ;
        dma_active <= 1'b1;
      end else if (!stall) begin
        if (byte_end) begin
          if (idx == LAST_IDX) begin
            state      <= IDLE;
            dma_active <= 1'b0;
          end else begin
            idx   <= idx + 8'd1;
            state <= READ;
          end
        end else begin
          case (state)
            READ: begin
              latch <= Di_mem;
              state <= WRITE;
            end
            WRITE: begin
              wait_cnt <= WAIT_LOAD;
              state    <= WAIT;
            end
            WAIT:    wait_cnt <= wait_cnt - WAIT_W'(1);
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    bus    = '{addr: A_cpu, dat: Di_cpu, rd_n: rd_cpu_n, wr_n: wr_cpu_n};
    Do_cpu = Di_mem;
    if ((state == IDLE) || stall) begin
      if (is_reg) begin
        bus.rd_n = 1'b1;
        bus.wr_n = 1'b1;
      end
    end else begin
      // CPU is locked out: reads float high, its strobes never reach memory.
      bus.rd_n = 1'b1;
      bus.wr_n = 1'b1;
      Do_cpu   = 8'hFF;
      case (state)
        READ: begin
          bus.addr = {src_eff, idx};
          bus.rd_n = 1'b0;
        end
        WRITE: begin
          bus.addr = OAM_BASE + {8'h00, idx};
          bus.dat  = latch;
          bus.wr_n = 1'b0;
        end
        default: ;
      endcase
    end
    if (is_reg) Do_cpu = src_raw;
  end

  assign A_mem    = bus.addr;
  assign Do_mem   = bus.dat;
  assign rd_mem_n = bus.rd_n;
  assign wr_mem_n = bus.wr_n;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Bench for oam_dma_controller: byte-level DMA model plus memory, checked every cycle.
module tb_oam_dma_controller;

  localparam int BC = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] A_cpu = 16'h0000;
  logic [7:0]  Di_cpu = 8'h00;
  logic        rd_cpu_n = 1'b1;
  logic        wr_cpu_n = 1'b1;
  logic [7:0]  Do_cpu;
  logic [15:0] A_mem;
  logic [7:0]  Do_mem;
  logic [7:0]  Di_mem;
  logic        rd_mem_n;
  logic        wr_mem_n;
  logic        dma_active;

  oam_dma_controller #(.BYTE_CYCLES(BC)) dut (
    .clock(clock), .reset(reset),
    .A_cpu(A_cpu), .Di_cpu(Di_cpu), .Do_cpu(Do_cpu),
    .rd_cpu_n(rd_cpu_n), .wr_cpu_n(wr_cpu_n),
    .A_mem(A_mem), .Do_mem(Do_mem), .Di_mem(Di_mem),
    .rd_mem_n(rd_mem_n), .wr_mem_n(wr_mem_n),
    .dma_active(dma_active)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] init_val(input logic [15:0] a);
    if (a[15:8] == 8'hC0) return a[7:0] ^ 8'h5A;
    if (a[15:8] == 8'hC1) return 8'hFF - a[7:0];
    if (a[15:8] == 8'hD0) return 8'(a[7:0] * 8'd7 + 8'd1);
    if (a >= 16'hFE00 && a <= 16'hFEA0) return 8'hEE;
    return 8'h00;
  endfunction

  // Memory behind the controller, plus the bench's golden copy of it.
  logic [7:0] mem  [0:65535];
  logic [7:0] gold [0:65535];
  logic env_init  = 1'b1;
  logic oam_clear = 1'b0;

  assign Di_mem = mem[A_mem];

  always @(posedge clock) begin
    if (env_init) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_val(16'(i));
    end else if (oam_clear) begin
      for (int i = 0; i < 160; i++) mem[16'hFE00 + i] <= 8'hEE;
    end else if (wr_mem_n === 1'b0) begin
      mem[A_mem] <= Do_mem;
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int n_print = 0;
  int act_cnt = 0;
  bit checks_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_print < 40) begin
        n_print++;
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
    end
  endtask

  // Byte-level model: each byte takes BC clocks, read in its first, OAM write in its second.
  bit         m_busy = 1'b0;
  logic [7:0] m_raw = 8'h00;
  logic [7:0] m_src = 8'h00;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] m_latch = 8'h00;
  int         m_phase = 0;
  bit         m_prev_wr = 1'b1;

  always @(negedge clock) begin
    logic        isreg, hram, pass, e_rd, e_wr, trig;
    logic [15:0] e_addr;
    logic [7:0]  e_dcpu, e_dmem;
    if (env_init)
      for (int i = 0; i < 65536; i++) gold[i] = init_val(16'(i));
    if (oam_clear)
      for (int i = 0; i < 160; i++) gold[16'hFE00 + i] = 8'hEE;

    isreg = (A_cpu == 16'hFF46);
    hram  = (!rd_cpu_n || !wr_cpu_n) && A_cpu >= 16'hFF80 && A_cpu <= 16'hFFFE;
    pass  = !m_busy || hram;
    e_addr = A_cpu;
    if (pass) begin
      e_dmem = Di_cpu;
      e_rd   = isreg ? 1'b1 : rd_cpu_n;
      e_wr   = isreg ? 1'b1 : wr_cpu_n;
      e_dcpu = isreg ? m_raw : gold[A_cpu];
    end else begin
      e_dmem = m_latch;
      e_rd   = 1'b1;
      e_wr   = 1'b1;
      e_dcpu = isreg ? m_raw : 8'hFF;
      if (m_phase == 0) begin
        e_rd   = 1'b0;
        e_addr = {m_src, m_byte};
      end else if (m_phase == 1) begin
        e_wr   = 1'b0;
        e_addr = 16'hFE00 + {8'h00, m_byte};
      end
    end

    if (checks_on) begin
      check("dma_active", dma_active, m_busy);
      check("rd_mem_n", rd_mem_n, e_rd);
      check("wr_mem_n", wr_mem_n, e_wr);
      if (!e_rd || !e_wr) check("A_mem", A_mem, e_addr);
      if (!e_wr) check("Do_mem", Do_mem, e_dmem);
      if (!rd_cpu_n) check("Do_cpu", Do_cpu, e_dcpu);
    end
    if (dma_active === 1'b1) act_cnt++;

    if (!e_wr) gold[e_addr] = e_dmem;
    if (reset) begin
      m_busy = 0; m_raw = 0; m_src = 0; m_byte = 0; m_phase = 0; m_latch = 0; m_prev_wr = 1;
    end else begin
      trig = m_prev_wr && !wr_cpu_n && isreg;
      if (!pass) begin
        if (m_phase == 0) m_latch = gold[{m_src, m_byte}];
        m_phase++;
        if (m_phase == BC) begin
          m_phase = 0;
          if (m_byte == 8'd159) m_busy = 0;
          else m_byte++;
        end
      end
      if (trig) begin
        m_raw   = Di_cpu;
        m_src   = (Di_cpu >= 8'hE0) ? Di_cpu - 8'h20 : Di_cpu;
        m_byte  = 0;
        m_phase = 0;
        m_busy  = 1;
      end
      m_prev_wr = wr_cpu_n;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    A_cpu = a; Di_cpu = d; wr_cpu_n = 1'b0;
    tick();
    wr_cpu_n = 1'b1; A_cpu = 16'h0000;
    tick();
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    A_cpu = a; rd_cpu_n = 1'b0;
    @(negedge clock);
    d = Do_cpu;
    tick();
    rd_cpu_n = 1'b1; A_cpu = 16'h0000;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (dma_active !== 1'b0 && n < 3000) begin
      tick();
      n++;
    end
    check("dma_done", dma_active, 1'b0);
  endtask

  task automatic seek(input logic [7:0] b, input int ph, input string name);
    int n = 0;
    while (!(m_busy && m_byte == b && m_phase == ph) && n < 2000) begin
      tick();
      n++;
    end
    check(name, (n < 2000), 1'b1);
  endtask

  task automatic clear_oam();
    oam_clear = 1'b1;
    tick();
    oam_clear = 1'b0;
  endtask

  task automatic check_oam(input logic [7:0] page, input int lo, input int hi, input string name);
    for (int i = lo; i <= hi; i++)
      check(name, mem[16'hFE00 + i], init_val({page, 8'(i)}));
  endtask

  initial begin
    logic [7:0] d;
    int start;
    repeat (3) @(posedge clock);
    #1;
    env_init = 1'b0;
    reset    = 1'b0;
    checks_on = 1'b1;

    check("rst_dma_active", dma_active, 1'b0);
    cpu_read(16'hFF46, d);
    check("rst_ff46", d, 8'h00);
    cpu_read(16'hC003, d);
    check("idle_passthru_rd", d, 8'h59);

    start = act_cnt;
    cpu_write(16'hFF46, 8'hC0);
    wait_idle();
    check("len_640", act_cnt - start, 640);
    check("oam_first", mem[16'hFE00], 8'h5A);
    check("oam_last", mem[16'hFE9F], 8'hC5);
    check_oam(8'hC0, 0, 159, "oam_c0");
    check("fea0_untouched", mem[16'hFEA0], 8'hEE);

    clear_oam();
    start = act_cnt;
    cpu_write(16'hFF46, 8'hC0);
    repeat (10) tick();
    cpu_read(16'h1234, d);
    check("blocked_rd", d, 8'hFF);
    cpu_write(16'hC000, 8'h77);
    cpu_write(16'hFF90, 8'h3C);
    cpu_read(16'hFF90, d);
    check("hram_rd", d, 8'h3C);
    wait_idle();
    check("len_stalled", act_cnt - start, 642);
    check("c000_kept", mem[16'hC000], 8'h5A);
    check_oam(8'hC0, 0, 159, "oam_stalled");

    clear_oam();
    cpu_write(16'hFF46, 8'hC0);
    seek(8'd80, 2, "reach_idx80");
    A_cpu = 16'hFF46; Di_cpu = 8'hD0; wr_cpu_n = 1'b0;
    tick();
    wr_cpu_n = 1'b1; A_cpu = 16'h0000;
    tick();
    wait_idle();
    check("restart_oam0", mem[16'hFE00], 8'h01);
    check_oam(8'hD0, 0, 159, "oam_restart");
    cpu_read(16'hFF46, d);
    check("ff46_d0", d, 8'hD0);

    clear_oam();
    cpu_write(16'hFF46, 8'hE1);
    wait_idle();
    check("echo_oam0", mem[16'hFE00], 8'hFF);
    check_oam(8'hC1, 0, 159, "oam_echo");
    cpu_read(16'hFF46, d);
    check("ff46_e1", d, 8'hE1);

    cpu_write(16'hFF46, 8'hC0);
    seek(8'd40, 0, "reach_idx40");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_inactive", dma_active, 1'b0);
    repeat (3) tick();
    check_oam(8'hC0, 0, 39, "oam_abort_head");
    check_oam(8'hC1, 40, 159, "oam_abort_tail");
    cpu_read(16'hFF46, d);
    check("abort_ff46", d, 8'h00);
    cpu_read(16'hC005, d);
    check("abort_passthru_rd", d, 8'h5F);
    cpu_write(16'hFE50, 8'h99);
    check("abort_passthru_wr", mem[16'hFE50], 8'h99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, %0d vectors so far", n_vec);
    $fatal(1);
  end

endmodule
